// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: round-robin sharing of one BRAM read port among N_REQ
// requesters. The read data goes back to the requester that was granted, after the fixed BRAM latency.
// Ports:
//   clk, reset (async, active low), enable (gates new grants)
//   req_valid/req_addr/req_ready : per-requester request handshake
//   resp_valid/resp_data         : one-hot response strobe, broadcast data
//   bram_r_addr/_valid/_data     : BRAM read port
//   busy                         : a read is in flight
//   conflict_clear/conflict_cycles : saturating contention counter
module bram_read_arbiter #(
   parameter int N_REQ        = 3,
   parameter int ADDR_WIDTH   = 9,
   parameter int DATA_WIDTH   = 64,
   parameter int READ_LATENCY = 1,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]       resp_data,
   output logic [ADDR_WIDTH-1:0]       bram_r_addr,
   output logic                        bram_r_valid,
   input  logic [DATA_WIDTH-1:0]       bram_r_data,
   output logic                        busy,
   input  logic                        conflict_clear,
   output logic [COUNT_WIDTH-1:0]      conflict_cycles
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

   logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;
   logic [READ_LATENCY-1:0]             tag_vld_q, tag_vld_d;
   logic [READ_LATENCY-1:0][PTR_W-1:0]  tag_id_q, tag_id_d;
   logic [COUNT_WIDTH-1:0]              conflict_q, conflict_d;

   logic             found;
   logic             grant;
   logic [PTR_W-1:0] winner;
   logic             multi;

   // Two passes give the circular scan: first the indices at or above
   // the pointer, then the ones below it.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
            found  = 1'b1;
            winner = PTR_W'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_valid[i]) begin
            found  = 1'b1;
            winner = PTR_W'(i);
         end
      end
   end

   // reset gates the grant so nothing is offered while in reset
   assign grant        = reset & enable & found;
   assign bram_r_valid = grant;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant && (winner == PTR_W'(i));
      end
   end

   always_comb begin
      bram_r_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            bram_r_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (winner == LAST) ? '0 : winner + PTR_W'(1);
      end
   end

   // Tag pipeline mirrors the BRAM latency; stage 0 loads every cycle
   always_comb begin
      tag_vld_d    = '0;
      tag_id_d     = '0;
      tag_vld_d[0] = grant;
      tag_id_d[0]  = winner;
      for (int s = 1; s < READ_LATENCY; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
      end
   end

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         resp_valid[i] = tag_vld_q[READ_LATENCY-1] &&
                         (tag_id_q[READ_LATENCY-1] == PTR_W'(i));
      end
   end

   assign resp_data = bram_r_data;
   assign busy      = |tag_vld_q;

   // More than one bit set: clearing the lowest set bit leaves something
   assign multi = |(req_valid & (req_valid - N_REQ'(1)));

   always_comb begin
      conflict_d = conflict_q;
      if (conflict_clear) begin
         conflict_d = '0;
      end else if (enable && multi && (conflict_q != '1)) begin
         conflict_d = conflict_q + COUNT_WIDTH'(1);
      end
   end

   assign conflict_cycles = conflict_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q   <= '0;
         tag_vld_q  <= '0;
         tag_id_q   <= '0;
         conflict_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         tag_vld_q  <= tag_vld_d;
         tag_id_q   <= tag_id_d;
         conflict_q <= conflict_d;
      end
   end

endmodule
